// File: rtl/sha256_core_arbiter.sv
// sha256_core_arbiter
// Shares a single-block SHA-256 compression core among NUM_REQ requesters.
// Round-robin grant, start/done level sequencing toward the core, digest
// return to the granted requester, and a watchdog that aborts a stuck core.
// Optional build macro: SHA_ARB_PRIORITY0_EN (requester 0 gets strict
// priority; the remaining requesters stay round-robin among themselves).
//
// Handshakes:
//   Requester side: a requester raises i_req_valid[i] with i_req_block slice i
//   stable and keeps both until o_req_ack[i] pulses for one cycle (the block
//   has then been copied). The answer comes later as a one-cycle
//   o_rsp_valid[i] pulse; o_rsp_err qualifies it and o_rsp_digest holds the
//   value until the next response.
//   Core side: o_core_start is a level held until i_core_done is seen, then
//   dropped; the next start is only issued once i_core_done has fallen.
module sha256_core_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     i_req_valid,
    input  logic [NUM_REQ*512-1:0] i_req_block,
    output logic [NUM_REQ-1:0]     o_req_ack,
    output logic [NUM_REQ-1:0]     o_rsp_valid,
    output logic [255:0]           o_rsp_digest,
    output logic                   o_rsp_err,
    output logic                   o_busy,
    output logic                   o_core_start,
    output logic [511:0]           o_core_block,
    input  logic [255:0]           i_core_result,
    input  logic                   i_core_done,
    output logic [1:0]             o_dbg_state
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] PTR_INIT   = GW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LAUNCH  = 2'd1,
        S_WAIT    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t          r_state;
    logic [GW-1:0]   r_grant;
    logic [GW-1:0]   r_ptr;
    logic [TW-1:0]   r_timer;

    logic [511:0]    w_blocks [NUM_REQ];
    logic [NUM_REQ-1:0] w_cand;
    logic [GW-1:0]   w_idx;
    logic [GW-1:0]   w_pick;
    logic            w_found;

    assign o_dbg_state = r_state;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign w_blocks[gi] = i_req_block[512*gi +: 512];
        end
    endgenerate

    // Grant selection: first pending requester after the last grant, wrapping.
    always_comb begin
        w_cand  = i_req_valid;
        w_pick  = '0;
        w_found = 1'b0;
        w_idx   = '0;
`ifdef SHA_ARB_PRIORITY0_EN
        // Requester 0 wins outright; the rotation only covers the others.
        w_cand[0] = 1'b0;
        if (i_req_valid[0]) begin
            w_found = 1'b1;
        end
`endif
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = GW'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && w_cand[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_ptr        <= PTR_INIT;
            r_timer      <= '0;
            o_req_ack    <= '0;
            o_rsp_valid  <= '0;
            o_rsp_digest <= '0;
            o_rsp_err    <= 1'b0;
            o_busy       <= 1'b0;
            o_core_start <= 1'b0;
            o_core_block <= '0;
        end else begin
            o_req_ack   <= '0;
            o_rsp_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_pick;
                        r_state <= S_LAUNCH;
                        o_busy  <= 1'b1;
                    end
                end
                S_LAUNCH: begin
                    // The block is copied here, so the requester may let go
                    // of its valid any time after the grant.
                    o_core_block <= w_blocks[r_grant];
                    o_core_start <= 1'b1;
                    o_req_ack    <= NUM_REQ'(1) << r_grant;
                    r_ptr        <= r_grant;
                    r_timer      <= '0;
                    r_state      <= S_WAIT;
                end
                S_WAIT: begin
                    r_timer <= r_timer + TW'(1);
                    if (i_core_done) begin
                        o_rsp_digest <= i_core_result;
                        o_rsp_err    <= 1'b0;
                        o_rsp_valid  <= NUM_REQ'(1) << r_grant;
                        o_core_start <= 1'b0;
                        r_state      <= S_RELEASE;
                    end else if (r_timer == TIMER_LAST) begin
                        o_rsp_digest <= '0;
                        o_rsp_err    <= 1'b1;
                        o_rsp_valid  <= NUM_REQ'(1) << r_grant;
                        o_core_start <= 1'b0;
                        r_state      <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    // Let the core fall back to idle before any new grant.
                    if (!i_core_done) begin
                        r_state <= S_IDLE;
                        o_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_core_arbiter.sv
// Bench for sha256_core_arbiter: a behavioural SHA-256 core stands in for the
// real core, a transaction-level arbitration model predicts each grant, and
// a negedge monitor checks acks, launched blocks and responses.
module tb_sha256_core_arbiter;

  localparam int N  = 4;
  localparam int TO = 255;
  localparam int EW = 8 + 512;

  localparam logic [255:0] ABC_D   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_D = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [511:0] ABC_B   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_B = {32'h80000000, 480'h0};

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset;
  logic [N-1:0]     req_valid;
  logic [N*512-1:0] req_block;
  logic [N-1:0]     req_ack;
  logic [N-1:0]     rsp_valid;
  logic [255:0]     rsp_digest;
  logic             rsp_err;
  logic             busy;
  logic             core_start;
  logic [511:0]     core_block;
  logic [255:0]     core_result;
  logic             core_done;
  logic [1:0]       dbg_state;

  always #5 clk = ~clk;

  sha256_core_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(req_valid), .i_req_block(req_block),
    .o_req_ack(req_ack), .o_rsp_valid(rsp_valid),
    .o_rsp_digest(rsp_digest), .o_rsp_err(rsp_err), .o_busy(busy),
    .o_core_start(core_start), .o_core_block(core_block),
    .i_core_result(core_result), .i_core_done(core_done),
    .o_dbg_state(dbg_state)
  );

  // ---------------- reference functions ----------------
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha256_blk(input logic [511:0] blk);
    logic [31:0] w [0:63];
    logic [31:0] hv [0:7];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    hv = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
           32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3];
    e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
    for (int i = 0; i < 64; i++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    return {a + hv[0], b + hv[1], c + hv[2], d + hv[3],
            e + hv[4], f + hv[5], g + hv[6], h + hv[7]};
  endfunction

  // Round-robin choice: first pending requester after ptr, modulo N.
  function automatic int pick(input logic [N-1:0] rv, input int ptr);
`ifdef SHA_ARB_PRIORITY0_EN
    if (rv[0]) return 0;
    rv[0] = 1'b0;
`endif
    for (int k = 1; k <= N; k++) begin
      if (rv[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [511:0] rand_blk();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- scoreboard bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expect_true(input string name, input logic cond);
    n_tests++;
    if (cond !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: got %b, need 1", name, cond);
    end
  endtask

  // ---------------- behavioural core ----------------
  bit core_hang = 1'b0;
  int core_lat  = 20;
  int core_cnt  = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_done   <= 1'b0;
      core_cnt    <= 0;
      core_result <= '0;
    end else if (!core_start) begin
      core_done <= 1'b0;
      core_cnt  <= 0;
    end else if (!core_done && !core_hang) begin
      if (core_cnt >= core_lat) begin
        core_done   <= 1'b1;
        core_result <= sha256_blk(core_block);
      end else begin
        core_cnt <= core_cnt + 1;
      end
    end
  end

  // ---------------- monitor / compare process ----------------
  logic [EW-1:0] exp_q [$];
  int           grant_log [$];
  int           cyc = 0;
  int           m_ptr = N - 1;
  logic [N-1:0] rv_q = '0;
  logic         busy_q = 1'b0;
  logic         start_q = 1'b0;
  logic         ack_due = 1'b0;
  logic         active = 1'b0;
  int           cur_g = 0;
  logic [511:0] cur_blk = '0;
  int           ack_cyc = 0;
  int           since_done = 100;
  int           rsp_cnt = 0;
  int           last_lat = 0;
  int           last_g = -1;
  logic         last_err = 1'b0;
  logic [255:0] last_digest = '0;
  int           mg;
  logic [EW-1:0] me;
  logic [N-1:0] one_n = 1;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      exp_q.delete();
      m_ptr = N - 1; rv_q = '0; busy_q = 1'b0; start_q = 1'b0;
      ack_due = 1'b0; active = 1'b0; since_done = 100; last_digest = '0;
    end else begin
      if (ack_due) expect_true("ack_one_cycle_after_grant", req_ack != '0);
      ack_due = 1'b0;
      if (busy && !busy_q) begin
        mg = pick(rv_q, m_ptr);
        expect_true("grant_has_pending_req", mg >= 0);
        if (mg >= 0) begin
          exp_q.push_back({8'(mg), req_block[mg*512 +: 512]});
          m_ptr = mg;
          ack_due = 1'b1;
        end
      end
      if (req_ack != '0) begin
        expect_true("ack_has_grant", exp_q.size() > 0);
        if (exp_q.size() > 0) begin
          me = exp_q.pop_front();
          mg = int'(me[EW-1:512]);
          check("req_ack", req_ack, one_n << mg);
          check("core_block", core_block, me[511:0]);
          check("core_start_at_ack", core_start, 1'b1);
          cur_g = mg; cur_blk = me[511:0];
          active = 1'b1; ack_cyc = cyc;
          grant_log.push_back(mg);
        end
      end
      if (rsp_valid != '0) begin
        expect_true("rsp_has_txn", active);
        if (active) begin
          check("rsp_valid", rsp_valid, one_n << cur_g);
          check("rsp_err", rsp_err, core_hang);
          check("rsp_digest", rsp_digest, core_hang ? 256'h0 : sha256_blk(cur_blk));
          active = 1'b0;
          last_lat = cyc - ack_cyc;
          last_g = cur_g; last_err = rsp_err;
          rsp_cnt++;
        end
        last_digest = rsp_digest;
      end else begin
        check("digest_held", rsp_digest, last_digest);
      end
      if (core_start && !start_q) expect_true("start_gap_after_done", since_done >= 2);
      if (core_done) since_done = 0; else since_done++;
      expect_true("start_implies_busy", !core_start || busy);
      busy_q = busy; rv_q = req_valid; start_q = core_start;
    end
  end

  // ---------------- driver tasks ----------------
  int cool [N];
  bit waiting [N];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int target, input int lim);
    int k;
    k = 0;
    while (rsp_cnt < target && k < lim) begin tick(); k++; end
    expect_true("rsp_within_bound", rsp_cnt >= target);
  endtask

  task automatic raise_and_ack(input int r, input logic [511:0] b);
    int k;
    req_block[r*512 +: 512] = b;
    req_valid[r] = 1'b1;
    k = 0;
    while (!req_ack[r] && k < 20) begin tick(); k++; end
    expect_true("ack_seen", req_ack[r]);
    req_valid[r] = 1'b0;
  endtask

  task automatic send_one(input int r, input logic [511:0] b, input int lim);
    int target;
    target = rsp_cnt + 1;
    raise_and_ack(r, b);
    wait_rsp(target, lim);
  endtask

  task automatic rand_step(input bit allow_new);
    tick();
    for (int i = 0; i < N; i++) begin
      if (rsp_valid[i]) waiting[i] = 1'b0;
      if (req_ack[i]) begin
        waiting[i] = 1'b1;
        req_valid[i] = 1'b0;
      end else if (cool[i] > 0) begin
        cool[i]--;
      end else if (req_valid[i] && $urandom_range(0, 40) == 0) begin
        req_valid[i] = 1'b0;
        cool[i] = 3;
      end else if (allow_new && !req_valid[i] && !waiting[i] && $urandom_range(0, 3) == 0) begin
        req_block[i*512 +: 512] = rand_blk();
        req_valid[i] = 1'b1;
      end
    end
    if ($urandom_range(0, 9) == 0) core_lat = $urandom_range(3, 80);
  endtask

  task automatic drain(input string name);
    int k;
    logic quiet;
    k = 0;
    quiet = 1'b0;
    while (!quiet && k < 3000) begin
      rand_step(1'b0);
      quiet = (req_valid == '0) && !busy && !active;
      for (int i = 0; i < N; i++) if (waiting[i]) quiet = 1'b0;
      k++;
    end
    expect_true(name, quiet);
  endtask

  function automatic int glog(input int idx);
    return (idx < grant_log.size()) ? grant_log[idx] : -1;
  endfunction

  // ---------------- stimulus ----------------
  int base, gl0;
  int seq_c [5];

  initial begin
    reset = 1'b1;
    req_valid = '0;
    req_block = '0;
    for (int i = 0; i < N; i++) begin cool[i] = 0; waiting[i] = 1'b0; end
    #2 reset = 1'b0;
    repeat (2) tick();
    check("rst_req_ack", req_ack, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_digest", rsp_digest, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_busy", busy, 0);
    check("rst_core_start", core_start, 0);
    check("rst_core_block", core_block, 0);
    reset = 1'b1;

    // Pin the reference hash against known digests.
    check("model_abc", sha256_blk(ABC_B), ABC_D);
    check("model_empty", sha256_blk(EMPTY_B), EMPTY_D);

    // All requesters held: rotation starts at 0 after reset.
`ifdef SHA_ARB_PRIORITY0_EN
    seq_c = '{0, 0, 0, 0, 0};
`else
    seq_c = '{0, 1, 2, 3, 0};
`endif
    core_lat = 30;
    gl0 = grant_log.size();
    base = rsp_cnt;
    for (int i = 0; i < N; i++) req_block[i*512 +: 512] = rand_blk();
    req_valid = '1;
    wait_rsp(base + 5, 1000);
    req_valid = '0;
    for (int i = 0; i < 5; i++) check("all_held_grant_order", glog(gl0 + i), seq_c[i]);
    drain("drain_all_held");

    // Known-answer transactions.
    core_lat = 70;
    send_one(1, ABC_B, 300);
    check("abc_digest", last_digest, ABC_D);
    check("abc_requester", last_g, 1);
    check("abc_err", last_err, 0);
    core_lat = 12;
    send_one(0, EMPTY_B, 300);
    check("empty_digest", last_digest, EMPTY_D);
    check("empty_requester", last_g, 0);

    // Randomized traffic.
    base = rsp_cnt;
    repeat (2500) rand_step(1'b1);
    drain("drain_random");
    expect_true("random_activity", rsp_cnt > base + 10);

    // Core that never finishes.
    core_hang = 1'b1;
    send_one(3, rand_blk(), 400);
    check("timeout_latency", last_lat, TO);
    check("timeout_err", last_err, 1);
    check("timeout_digest", last_digest, 0);
    check("timeout_start_low", core_start, 0);
    tick(); tick();
    check("timeout_back_idle", busy, 0);
    core_hang = 1'b0;

    // Reset while waiting on the core.
    core_lat = 70;
    raise_and_ack(2, rand_blk());
    repeat (30) tick();
    #2 reset = 1'b0;
    #1;
    check("midrst_core_start", core_start, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_core_block", core_block, 0);
    req_valid = '0;
    tick(); tick();
    reset = 1'b1;
    send_one(1, ABC_B, 300);
    check("post_rst_abc_digest", last_digest, ABC_D);
    check("post_rst_abc_err", last_err, 0);

    // Requesters 0 and 2 held together, then 0 withdraws.
    core_lat = 8;
    gl0 = grant_log.size();
    base = rsp_cnt;
    req_block[0 +: 512] = rand_blk();
    req_block[1024 +: 512] = rand_blk();
    req_valid[0] = 1'b1;
    req_valid[2] = 1'b1;
    wait_rsp(base + 3, 500);
    req_valid[0] = 1'b0;
    wait_rsp(base + 4, 300);
    req_valid[2] = 1'b0;
`ifdef SHA_ARB_PRIORITY0_EN
    check("prio_grant_0", glog(gl0), 0);
    check("prio_grant_1", glog(gl0 + 1), 0);
    check("prio_grant_2", glog(gl0 + 2), 0);
    check("prio_grant_3", glog(gl0 + 3), 2);
`endif
    drain("drain_prio");
    check("no_leftover_grants", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    n_tests++;
    n_fail++;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "time budget exceeded");
  end

endmodule
